// File: rtl/dec_pipe_pkg.sv
// ---------------------------------------------------------------------------
// dec_pipe_pkg : occupancy encoding and decode helpers for dec_pipe
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dec_pipe_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t ST_EMPTY = 2'd0;
  localparam occ_t ST_ONE   = 2'd1;
  localparam occ_t ST_FULL  = 2'd2;

  // Bit k of the decode; codes past num_out never select anything.
  function automatic logic dec_onehot(input int unsigned sel,
                                      input int unsigned k,
                                      input int unsigned num_out,
                                      input logic        active_low);
    return ((sel == k) && (k < num_out)) ^ active_low;
  endfunction

  function automatic logic inactive_level(input logic active_low);
    return active_low;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dec_core.sv
// ---------------------------------------------------------------------------
// dec_core : combinational SEL_W -> NUM_OUT one-hot/one-cold decode + range flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dec_core
  import dec_pipe_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter int ACTIVE_LOW = 0,
  parameter bit RANGE_EN   = 1'b0
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] y,
  output logic               range_err
);

  genvar k;
  generate
    for (k = 0; k < NUM_OUT; k++) begin : g_bit
      assign y[k] = dec_onehot(32'(sel), k, NUM_OUT, ACTIVE_LOW != 0);
    end

    // A fully populated code space can never be out of range.
    if (!RANGE_EN || (NUM_OUT == (1 << SEL_W))) begin : g_range_off
      assign range_err = 1'b0;
    end else begin : g_range_on
      assign range_err = (32'(sel) >= 32'(NUM_OUT));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dec_pipe.sv
// ---------------------------------------------------------------------------
// dec_pipe : registered N-to-M decoder with skid-buffered valid/ready handshake
//            optional range flag via `define DEC_PIPE_RANGE_CHK_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dec_pipe
  import dec_pipe_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_y,
  output logic               out_err
);

  localparam logic [NUM_OUT-1:0] c_inactive = {NUM_OUT{inactive_level(ACTIVE_LOW != 0)}};

`ifdef DEC_PIPE_RANGE_CHK_EN
  localparam bit c_range_en = 1'b1;
`else
  localparam bit c_range_en = 1'b0;
`endif

  occ_t               r_state;
  occ_t               w_state_nxt;
  logic               r_in_ready;
  logic [SEL_W-1:0]   r_skid_sel;
  logic [NUM_OUT-1:0] r_out_y;
  logic [NUM_OUT-1:0] w_dec_y;
  logic               w_dec_err;
  logic [SEL_W-1:0]   w_load_sel;
  logic               w_load_out;
  logic               w_load_skid;
  logic               w_acc;
  logic               w_cons;

  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = r_in_ready;
  assign out_y     = r_out_y;

  assign w_acc  = in_valid && r_in_ready;
  assign w_cons = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_out  = 1'b0;
    w_load_skid = 1'b0;
    w_load_sel  = in_sel;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_load_out  = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_acc && w_cons) begin
          w_load_out = 1'b1;
        end else if (w_cons) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_acc) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the skid entry can move forward.
        if (w_cons) begin
          w_load_out  = 1'b1;
          w_load_sel  = r_skid_sel;
          w_state_nxt = ST_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  dec_core #(
    .SEL_W      (SEL_W),
    .NUM_OUT    (NUM_OUT),
    .ACTIVE_LOW (ACTIVE_LOW),
    .RANGE_EN   (c_range_en)
  ) u_dec_core (
    .sel       (w_load_sel),
    .y         (w_dec_y),
    .range_err (w_dec_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
      r_skid_sel <= '0;
      r_out_y    <= c_inactive;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
      if (w_load_skid) begin
        r_skid_sel <= in_sel;
      end
      if (w_load_out) begin
        r_out_y <= w_dec_y;
      end
    end
  end

`ifdef DEC_PIPE_RANGE_CHK_EN
  logic r_out_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_err <= 1'b0;
    end else if (w_load_out) begin
      r_out_err <= w_dec_err;
    end
  end

  assign out_err = r_out_err;
`else
  // Decoder built without range logic, so this is a constant 0.
  assign out_err = w_dec_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dec_pipe.sv
// ---------------------------------------------------------------------------
// tb_dec_pipe : scoreboard bench for dec_pipe (default, NUM_OUT=3, ACTIVE_LOW=1)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dec_pipe;

`ifdef DEC_PIPE_RANGE_CHK_EN
  localparam logic c_err_en = 1'b1;
`else
  localparam logic c_err_en = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0] in_sel;
  logic [3:0] out_y;

  logic       v3, rdy3, ov3, or3, err3;
  logic [1:0] s3;
  logic [2:0] y3;

  logic       val, rdyal, oval, oral, erral;
  logic [1:0] sal;
  logic [3:0] yal;

  int total = 0;
  int bad   = 0;
  int pushed = 0;
  int popped = 0;
  logic [4:0] q[$];
  logic       prev_stall;
  logic [3:0] held_y;
  logic       held_err;

  always #5 clk = ~clk;

  dec_pipe #(.SEL_W(2), .NUM_OUT(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_err(out_err)
  );

  dec_pipe #(.SEL_W(2), .NUM_OUT(3), .ACTIVE_LOW(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3),
    .in_sel(s3), .out_valid(ov3), .out_ready(or3),
    .out_y(y3), .out_err(err3)
  );

  dec_pipe #(.SEL_W(2), .NUM_OUT(4), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .in_valid(val), .in_ready(rdyal),
    .in_sel(sal), .out_valid(oval), .out_ready(oral),
    .out_y(yal), .out_err(erral)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model(input logic [1:0] sel);
    logic [3:0] y;
    y      = 4'b0000;
    y[sel] = 1'b1;
    return {1'b0, y};
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    logic [4:0] e;
    if (prev_stall) begin
      chk("stall_y", 32'(out_y), 32'(held_y));
      chk("stall_err", 32'(out_err), 32'(held_err));
    end
    if (out_valid && out_ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected observed=%0h expected=none", out_y);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        popped++;
        chk("sb_y", 32'(out_y), 32'(e[3:0]));
        chk("sb_err", 32'(out_err), 32'(e[4]));
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(in_sel));
      pushed++;
    end
    prev_stall = out_valid && !out_ready;
    held_y     = out_y;
    held_err   = out_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; out_ready = 1'b0;
    v3 = 1'b0; s3 = 2'd0; or3 = 1'b1;
    val = 1'b0; sal = 2'd0; oral = 1'b1;
    prev_stall = 1'b0; held_y = 4'b0; held_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_al_y", 32'(yal), 32'hF);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Side instances: out-of-range code and active-low decode.
    chk("n3_in_ready", 32'(rdy3), 1);
    chk("al_in_ready", 32'(rdyal), 1);
    v3 = 1'b1; s3 = 2'd3; val = 1'b1; sal = 2'd2;
    @(posedge clk); @(negedge clk);
    chk("n3_valid", 32'(ov3), 1);
    chk("n3_y_oor", 32'(y3), 0);
    chk("n3_err_oor", 32'(err3), 32'(c_err_en));
    chk("al_valid", 32'(oval), 1);
    chk("al_y", 32'(yal), 32'hB);
    chk("al_err", 32'(erral), 0);
    s3 = 2'd2; val = 1'b0;
    @(posedge clk); @(negedge clk);
    v3 = 1'b0;
    chk("n3_y_2", 32'(y3), 32'h4);
    chk("n3_err_2", 32'(err3), 0);

    // Back-to-back decode, consumer always ready.
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_valid = 1'b1;
      in_sel   = 2'(s);
      tick();
      chk("t1_in_ready", 32'(in_ready), 1);
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_y", 32'(out_y), 32'(1 << s));
    end
    in_valid = 1'b0;
    tick();
    chk("t1_idle_valid", 32'(out_valid), 0);

    // Stalled consumer fills the skid; extra pushes are ignored.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1;
    tick();
    in_sel = 2'd2;
    tick();
    chk("t2_full_in_ready", 32'(in_ready), 0);
    chk("t2_held_y", 32'(out_y), 32'h2);
    in_sel = 2'd3;
    tick();
    tick();
    chk("t2_still_held", 32'(out_y), 32'h2);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("t2_second_y", 32'(out_y), 32'h4);
    chk("t2_in_ready_back", 32'(in_ready), 1);
    tick();
    chk("t2_drained", 32'(out_valid), 0);
    chk("t2_sb_empty", 32'(q.size()), 0);

    // Random valid/ready traffic.
    sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while (q.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("t3_sent", 32'(sent), 1000);
    chk("t3_sb_empty", 32'(q.size()), 0);
    chk("t3_push_pop", 32'(popped), 32'(pushed));
    chk("t3_idle_valid", 32'(out_valid), 0);

    // Reset while FULL discards both entries.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1;
    tick();
    in_sel = 2'd2;
    tick();
    chk("t4_full", 32'(in_ready), 0);
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t4_rst_valid", 32'(out_valid), 0);
    chk("t4_rst_in_ready", 32'(in_ready), 0);
    chk("t4_rst_y", 32'(out_y), 0);
    rst_n = 1'b1;
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t4_in_ready", 32'(in_ready), 1);
    chk("t4_no_stale", 32'(out_valid), 0);
    out_ready = 1'b1;
    tick();
    chk("t4_no_stale2", 32'(out_valid), 0);
    in_valid = 1'b1; in_sel = 2'd3;
    tick();
    chk("t4_fresh_y", 32'(out_y), 32'h8);
    in_valid = 1'b0;
    tick();
    chk("t4_sb_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
